// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART/ALU command path: opcodes, FSM states and
// the opcode validity check. The ALU decodes the same opcode constants.
package uart_alu_pkg;

   localparam int               OP_W_DEF     = 6;
   localparam logic [7:0]       ERR_BYTE_DEF = 8'hEE;

   localparam logic [OP_W_DEF-1:0] OP_ADD = 6'h20;
   localparam logic [OP_W_DEF-1:0] OP_SUB = 6'h22;
   localparam logic [OP_W_DEF-1:0] OP_AND = 6'h24;
   localparam logic [OP_W_DEF-1:0] OP_OR  = 6'h25;
   localparam logic [OP_W_DEF-1:0] OP_XOR = 6'h26;
   localparam logic [OP_W_DEF-1:0] OP_NOR = 6'h27;
   localparam logic [OP_W_DEF-1:0] OP_SRA = 6'h03;
   localparam logic [OP_W_DEF-1:0] OP_SRL = 6'h02;

   typedef enum logic [2:0] {
      ST_WAIT_A  = 3'd0,
      ST_WAIT_B  = 3'd1,
      ST_WAIT_OP = 3'd2,
      ST_EXEC    = 3'd3,
      ST_SEND    = 3'd4,
      ST_WAIT_TX = 3'd5
   } state_t;

   // True for the eight opcodes the ALU implements.
   function automatic logic is_valid_op(input logic [OP_W_DEF-1:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
         default:                        return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/uart_alu_ctrl_if.sv
// Bundle between the command sequencer and its neighbours (UART RX/TX, ALU).
// slave is the sequencer's view, master is the surrounding logic's view.
interface uart_alu_ctrl_if #(
   parameter int DATA_W = 8,
   parameter int OP_W   = 6
);
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              tx_busy;
   logic              tx_done;
   logic              tx_start;
   logic [DATA_W-1:0] tx_data;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [OP_W-1:0]   alu_op;
   logic [DATA_W-1:0] alu_result;
   logic              busy;
   logic              err_timeout;
   logic              err_opcode;
   logic              overrun;

   modport slave (
      input  rx_data, rx_valid, tx_busy, tx_done, alu_result,
      output tx_start, tx_data, alu_a, alu_b, alu_op, busy,
             err_timeout, err_opcode, overrun
   );

   modport master (
      output rx_data, rx_valid, tx_busy, tx_done, alu_result,
      input  tx_start, tx_data, alu_a, alu_b, alu_op, busy,
             err_timeout, err_opcode, overrun
   );
endinterface

// File: rtl/uart_alu_timer.sv
// Inter-byte timeout counter: clears on request, counts while enabled and
// saturates at TIMEOUT_CYC. expire_o flags the last allowed cycle.
module uart_alu_timer #(
   parameter int TIMEOUT_CYC = 520830
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);
   localparam int               CNT_W   = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_EXP = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next count: clear wins, otherwise count up without wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && cnt_q != CNT_MAX)
         cnt_d = cnt_q + CNT_W'(1);
   end

   // Counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign expire_o = en_i && (cnt_q == CNT_EXP);

endmodule

// File: rtl/uart_alu_ctrl.sv
// Command sequencer: gathers A, B, opcode from the UART receiver, runs the
// ALU for one cycle and hands the result byte to the UART transmitter.
module uart_alu_ctrl
   import uart_alu_pkg::*;
#(
   parameter int                DATA_W      = 8,
   parameter int                OP_W        = OP_W_DEF,
   parameter int                TIMEOUT_CYC = 520830,
   parameter logic [DATA_W-1:0] ERR_BYTE    = ERR_BYTE_DEF
) (
   input logic            clk,
   input logic            reset,
   uart_alu_ctrl_if.slave bus
);
   state_t            state_q;
   logic [DATA_W-1:0] alu_a_q, alu_b_q, result_q, tx_data_q;
   logic [OP_W-1:0]   alu_op_q;
   logic              tx_start_q, busy_q;
   logic              err_timeout_q, err_opcode_q, overrun_q;

   logic              in_frame, timer_clr, tmo_expire, rx_dropped;
   logic [OP_W-1:0]   opcode;

   assign opcode     = bus.rx_data[OP_W-1:0];
   // Timer only runs between bytes of a frame; any accepted byte restarts it.
   assign in_frame   = (state_q == ST_WAIT_B) || (state_q == ST_WAIT_OP);
   assign timer_clr  = !in_frame || bus.rx_valid;
   assign rx_dropped = bus.rx_valid &&
                       (state_q inside {ST_EXEC, ST_SEND, ST_WAIT_TX});

   uart_alu_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (timer_clr),
      .en_i     (in_frame),
      .expire_o (tmo_expire)
   );

   // Frame FSM with registered outputs; strobes default low every cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_WAIT_A;
         alu_a_q       <= '0;
         alu_b_q       <= '0;
         alu_op_q      <= '0;
         result_q      <= '0;
         tx_data_q     <= '0;
         tx_start_q    <= 1'b0;
         busy_q        <= 1'b0;
         err_timeout_q <= 1'b0;
         err_opcode_q  <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         tx_start_q    <= 1'b0;
         err_timeout_q <= 1'b0;
         err_opcode_q  <= 1'b0;
         overrun_q     <= rx_dropped;
         case (state_q)
            ST_WAIT_A: begin
               if (bus.rx_valid) begin
                  alu_a_q <= bus.rx_data;
                  state_q <= ST_WAIT_B;
               end
            end
            ST_WAIT_B: begin
               // A byte arriving on the expiry cycle still counts.
               if (bus.rx_valid) begin
                  alu_b_q <= bus.rx_data;
                  state_q <= ST_WAIT_OP;
               end else if (tmo_expire) begin
                  err_timeout_q <= 1'b1;
                  state_q       <= ST_WAIT_A;
               end
            end
            ST_WAIT_OP: begin
               if (bus.rx_valid) begin
                  busy_q <= 1'b1;
                  if (is_valid_op(opcode)) begin
                     alu_op_q <= opcode;
                     state_q  <= ST_EXEC;
                  end else begin
                     // Reply with the error byte; ALU inputs stay untouched.
                     err_opcode_q <= 1'b1;
                     result_q     <= ERR_BYTE;
                     state_q      <= ST_SEND;
                  end
               end else if (tmo_expire) begin
                  err_timeout_q <= 1'b1;
                  state_q       <= ST_WAIT_A;
               end
            end
            ST_EXEC: begin
               result_q <= bus.alu_result;
               state_q  <= ST_SEND;
            end
            ST_SEND: begin
               if (!bus.tx_busy) begin
                  tx_start_q <= 1'b1;
                  tx_data_q  <= result_q;
                  state_q    <= ST_WAIT_TX;
               end
            end
            ST_WAIT_TX: begin
               if (bus.tx_done) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_WAIT_A;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_WAIT_A;
            end
         endcase
      end
   end

   assign bus.alu_a       = alu_a_q;
   assign bus.alu_b       = alu_b_q;
   assign bus.alu_op      = alu_op_q;
   assign bus.tx_start    = tx_start_q;
   assign bus.tx_data     = tx_data_q;
   assign bus.busy        = busy_q;
   assign bus.err_timeout = err_timeout_q;
   assign bus.err_opcode  = err_opcode_q;
   assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Bench for uart_alu_ctrl: directed frames plus random frames, with a
// scoreboard of expected strobes/bytes popped by an independent monitor.
module tb_uart_alu_ctrl;

   localparam int TMO = 16;
   localparam logic [1:0] K_TX = 2'd0, K_EOP = 2'd1, K_TMO = 2'd2, K_OVR = 2'd3;

   typedef struct packed {
      logic [1:0] kind;
      logic [7:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;
   exp_t expq[$];

   logic tx_busy_m = 1'b0, tx_done_m = 1'b0, hold_busy = 1'b0;
   int   tx_len = 4;
   logic [7:0] model_a = 8'h00;
   logic [5:0] model_op = 6'h00;
   logic [7:0] valid_ops [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};

   uart_alu_ctrl_if #(.DATA_W(8), .OP_W(6)) bus ();

   uart_alu_ctrl #(.DATA_W(8), .OP_W(6), .TIMEOUT_CYC(TMO), .ERR_BYTE(8'hEE)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Behavioural ALU: what each opcode means in plain arithmetic.
   function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [5:0] op);
      case (op)
         6'h20:   return a + b;
         6'h22:   return a - b;
         6'h24:   return a & b;
         6'h25:   return a | b;
         6'h26:   return a ^ b;
         6'h27:   return ~(a | b);
         6'h03:   return $signed(a) >>> b;
         6'h02:   return a >> b;
         default: return 8'h00;
      endcase
   endfunction

   function automatic bit op_ok(input logic [7:0] op);
      for (int i = 0; i < 8; i++)
         if (valid_ops[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   assign bus.alu_result = alu_model(bus.alu_a, bus.alu_b, bus.alu_op);
   assign bus.tx_busy    = tx_busy_m | hold_busy;
   assign bus.tx_done    = tx_done_m;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [1:0] k, input logic [7:0] d);
      exp_t e;
      e.kind = k;
      e.data = d;
      expq.push_back(e);
   endtask

   // Scoreboard pop for one observed strobe.
   task automatic mon_evt(input logic [1:0] k, input logic [7:0] d);
      exp_t e;
      if (expq.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL sb_unexpected kind=%0d data=0x%0h required=none t=%0t", k, d, $time);
      end else begin
         e = expq.pop_front();
         chk("sb_kind", int'(k), int'(e.kind));
         if (k == K_TX) chk("sb_tx_data", int'(d), int'(e.data));
      end
   endtask

   // Monitor: every output strobe must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.err_timeout) mon_evt(K_TMO, 8'h00);
         if (bus.err_opcode)  mon_evt(K_EOP, 8'h00);
         if (bus.overrun)     mon_evt(K_OVR, 8'h00);
         if (bus.tx_start)    mon_evt(K_TX, bus.tx_data);
      end
   end

   // Transmitter model: busy for tx_len cycles after each start, then done.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.tx_start) begin
            tx_busy_m = 1'b1;
            repeat (tx_len) @(negedge clk);
            tx_done_m = 1'b1;
            @(negedge clk);
            tx_done_m = 1'b0;
            tx_busy_m = 1'b0;
         end
      end
   end

   // Called at a negedge; byte is sampled on the following posedge.
   task automatic send_byte(input logic [7:0] d);
      bus.rx_data  = d;
      bus.rx_valid = 1'b1;
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                        input int gap);
      send_byte(a);
      model_a = a;
      repeat (gap) @(negedge clk);
      send_byte(b);
      repeat (gap) @(negedge clk);
      if (op_ok(op)) begin
         push(K_TX, alu_model(a, b, op[5:0]));
         model_op = op[5:0];
      end else begin
         push(K_EOP, 8'h00);
         push(K_TX, 8'hEE);
      end
      send_byte(op);
   endtask

   task automatic wait_done();
      int n = 0;
      while ((bus.busy || tx_busy_m || tx_done_m) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("frame_completes", int'(n < 300), 1);
      @(negedge clk);
   endtask

   task automatic wait_start(output int n);
      n = 0;
      while (!bus.tx_start && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [7:0] a, b, op;
      int kind, g;
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;

      // Reset state
      #12;
      chk("rst_tx_start", int'(bus.tx_start), 0);
      chk("rst_tx_data", int'(bus.tx_data), 0);
      chk("rst_alu_abop", int'({bus.alu_a, bus.alu_b, bus.alu_op}), 0);
      chk("rst_flags", int'({bus.busy, bus.err_timeout, bus.err_opcode, bus.overrun}), 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // ADD with latency and busy checks
      frame(8'h05, 8'h03, 8'h20, 0);
      chk("busy_after_op", int'(bus.busy), 1);
      wait_start(n);
      chk("add_latency", n, 2);
      chk("add_tx_data", int'(bus.tx_data), 8'h08);
      wait_done();
      chk("busy_idle", int'(bus.busy), 0);

      frame(8'h03, 8'h05, 8'h22, 1);
      wait_done();
      frame(8'hF0, 8'h02, 8'h03, 0);
      wait_done();
      chk("sra_alu_op", int'(bus.alu_op), 8'h03);

      // Invalid opcode
      frame(8'h01, 8'h02, 8'h3F, 0);
      chk("err_opcode_now", int'(bus.err_opcode), 1);
      wait_start(n);
      chk("err_latency", n, 1);
      wait_done();
      chk("err_keeps_op", int'(bus.alu_op), 8'h03);

      // Timeout in WAIT_B
      push(K_TMO, 8'h00);
      send_byte(8'h11);
      n = 0;
      while (!bus.err_timeout && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("tmo_cycles", n, TMO);
      chk("tmo_keeps_a", int'(bus.alu_a), 8'h11);
      chk("tmo_not_busy", int'(bus.busy), 0);
      @(negedge clk);
      frame(8'h02, 8'h02, 8'h20, 0);
      wait_done();

      // Byte on the expiry cycle is accepted
      send_byte(8'h21);
      repeat (TMO - 1) @(negedge clk);
      send_byte(8'h13);
      push(K_TX, alu_model(8'h21, 8'h13, 6'h26));
      model_op = 6'h26;
      send_byte(8'h26);
      wait_done();
      chk("edge_alu_b", int'(bus.alu_b), 8'h13);

      // Timeout in WAIT_OP keeps operands
      push(K_TMO, 8'h00);
      send_byte(8'h44);
      send_byte(8'h55);
      repeat (TMO + 2) @(negedge clk);
      chk("tmo_op_keeps_ab", int'({bus.alu_a, bus.alu_b}), 16'h4455);

      // tx_busy held over SEND, overrun in WAIT_TX
      hold_busy = 1'b1;
      frame(8'h07, 8'h09, 8'h20, 1);
      n = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.tx_start) n++;
      end
      chk("start_held", n, 0);
      hold_busy = 1'b0;
      wait_start(n);
      chk("start_after_release", n, 1);
      push(K_OVR, 8'h00);
      send_byte(8'h5A);
      chk("overrun_pulse", int'(bus.overrun), 1);
      chk("overrun_no_latch", int'(bus.alu_a), 8'h07);
      @(negedge clk);
      chk("overrun_once", int'(bus.overrun), 0);
      wait_done();

      // Reset in WAIT_TX, stray tx_done afterwards
      frame(8'h04, 8'h04, 8'h20, 0);
      wait_start(n);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("mid_rst_outs", int'({bus.tx_data, bus.alu_a, bus.alu_b, bus.alu_op}), 0);
      chk("mid_rst_flags", int'({bus.busy, bus.tx_start, bus.err_timeout, bus.err_opcode, bus.overrun}), 0);
      model_a  = 8'h00;
      model_op = 6'h00;
      @(negedge clk);
      reset = 1'b0;
      n = 0;
      while ((tx_busy_m || tx_done_m) && n < 40) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      chk("stray_done_ignored", int'(bus.busy), 0);
      frame(8'h0A, 8'h03, 8'h22, 0);
      wait_done();
      chk("post_rst_op", int'(bus.alu_op), 8'h22);

      // Random frames
      for (int it = 0; it < 40; it++) begin
         tx_len = $urandom_range(1, 6);
         kind   = $urandom_range(0, 9);
         a      = 8'($urandom);
         b      = 8'($urandom);
         if (kind == 0) begin
            push(K_TMO, 8'h00);
            send_byte(a);
            model_a = a;
            repeat (TMO + 2) @(negedge clk);
         end else begin
            op = (kind <= 7) ? valid_ops[$urandom_range(0, 7)] : 8'($urandom_range(0, 63));
            g  = $urandom_range(0, 3);
            frame(a, b, op, g);
            wait_done();
            chk("rand_alu_op", int'(bus.alu_op), int'(model_op));
         end
         chk("rand_alu_a", int'(bus.alu_a), int'(model_a));
      end

      repeat (4) @(negedge clk);
      chk("sb_drained", expq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_alu_ctrl.md
# uart_alu_ctrl

Command sequencer between the UART receiver, the ALU and the UART transmitter. It collects a three-byte command frame from the receiver (operand A, operand B, opcode), drives the ALU, and captures the result. It then hands the result byte to the transmitter through a start/done handshake. It is the only block that writes ALU inputs or starts a UART transmission.

## Interface
Parameters:
- DATA_W, 8, operand/result width; equals UART data bits
- OP_W, 6, opcode width; opcode = rx_data[OP_W-1:0]
- TIMEOUT_CYC, 520830, max clk cycles allowed between bytes of one frame
- ERR_BYTE, 8'hEE, byte transmitted on invalid opcode

Ports (reset reset, asynchronous, active-high; clock clk):
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- rx_data  in  DATA_W  received byte, valid with rx_valid
- rx_valid  in  1  one-cycle strobe per received byte
- tx_busy  in  1  transmitter occupied
- tx_done  in  1  one-cycle strobe, end of stop bit(s)
- tx_start  out  1  one-cycle transmit request
- tx_data  out  DATA_W  byte to send; stable from tx_start until tx_done
- alu_a, alu_b  out  DATA_W  latched operands
- alu_op  out  OP_W  latched opcode
- alu_result  in  DATA_W  combinational ALU result
- busy  out  1  high in EXEC, SEND, WAIT_TX
- err_timeout, err_opcode, overrun  out  1  one-cycle error strobes

## Operation
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
- Reset: state WAIT_A. All outputs 0. Timer 0. Result register 0.
- WAIT_A: rx_valid → alu_a<=rx_data, timer<=0, go to WAIT_B. No timeout in this state.
- WAIT_B: rx_valid → alu_b<=rx_data, timer<=0, go to WAIT_OP.
- WAIT_OP, valid opcode (ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SRA 0x03, SRL 0x02; bits above OP_W zero) → alu_op<=opcode, go to EXEC.
- WAIT_OP, any other opcode → err_opcode strobe, result<=ERR_BYTE, alu_op unchanged, go to SEND.
- EXEC: one cycle. result<=alu_result, go to SEND.
- SEND: when tx_busy=0 → tx_start=1, tx_data<=result, go to WAIT_TX. Otherwise hold in SEND.
- WAIT_TX: tx_done → go to WAIT_A. tx_done in any other state is ignored.
- Timeout: in WAIT_B/WAIT_OP the timer counts every cycle. At timer==TIMEOUT_CYC-1 with no rx_valid: err_timeout strobe, go to WAIT_A. alu_a/alu_b keep their values.
- rx_valid in the same cycle as timeout expiry: the byte is accepted; no timeout.
- rx_valid in EXEC/SEND/WAIT_TX: byte dropped, overrun strobe, state unchanged.
- Timer width $clog2(TIMEOUT_CYC+1). The timer saturates and never wraps.

## Timing
- All outputs are registered. Strobes are high the cycle after the triggering edge, for exactly one cycle.
- Valid opcode sampled at edge k: EXEC after k, SEND after k+1, tx_start high after edge k+2. Latency is 3 cycles with tx_busy=0.
- Invalid opcode at edge k: tx_start high after edge k+1. err_opcode high after edge k.
- tx_busy high in SEND: tx_start is delayed until the first cycle with tx_busy=0. tx_start is never issued twice per frame.
- alu_a/alu_b/alu_op are stable from EXEC through WAIT_TX.
- Reset asserted mid-operation (any state): immediate return to WAIT_A with all outputs 0. A pending tx_done after release is ignored.

## Structure
- Shared package uart_alu_pkg holds:
  - opcode localparams
  - state encoding (3-bit)
  - ERR_BYTE default
  - is_valid_op() function
- The same opcode constants are reused by the ALU.
- Sub-module uart_alu_timer: clear/enable/expire counter parameterised by TIMEOUT_CYC. The FSM and datapath registers stay in uart_alu_ctrl.

## Test plan
Bench uses TIMEOUT_CYC=16 and a behavioural ALU model.
- Bytes 0x05, 0x03, 0x20, tx_busy=0 → tx_start 3 cycles after third rx_valid, tx_data=0x08. busy=1 until tx_done, then 0.
- Bytes 0x03, 0x05, 0x22 → tx_data=0xFE. Then 0xF0, 0x02, 0x03 (SRA) → tx_data=0xFC.
- Bytes 0x01, 0x02, 0x3F → err_opcode pulse, tx_data=0xEE, alu_op keeps prior value.
- Byte 0x11, then idle 16 cycles → err_timeout pulse on cycle 16, state WAIT_A. Next frame 0x02, 0x02, 0x20 → tx_data=0x04.
- tx_busy held high over SEND, rx_valid injected in WAIT_TX → tx_start waits for tx_busy=0, overrun pulses once, byte not latched into alu_a.
- Reset asserted in WAIT_TX → all outputs 0. Stray tx_done ignored. Next frame processed normally.
